// File: rtl/lms_ctrlport_if.sv
// CtrlPort request/response bundle between the NoC shell master
// and the LMS register responder.
interface lms_ctrlport_if;
    logic        req_wr;
    logic        req_rd;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic        resp_ack;
    logic [31:0] resp_data;

    modport master (
        output req_wr, req_rd, req_addr, req_data,
        input  resp_ack, resp_data
    );

    modport slave (
        input  req_wr, req_rd, req_addr, req_data,
        output resp_ack, resp_data
    );
endinterface

// File: rtl/lms_ctrlport_regs.sv
// CtrlPort register file for the LMS filter: config registers plus
// coefficient readback fetched from the core with a timeout.
module lms_ctrlport_regs #(
    parameter logic [19:0] BASE_ADDR  = 20'h00000,
    parameter int          NUM_TAPS   = 32,
    parameter int          TAP_IDX_W  = 5,
    parameter logic [15:0] MU_DEFAULT = 16'h0100,
    parameter int          TIMEOUT    = 255
) (
    input  logic                 ctrlport_clk,
    input  logic                 ctrlport_rst_n,
    lms_ctrlport_if.slave        s_ctrlport,
    output logic                 lms_enable,
    output logic                 lms_adapt_en,
    output logic                 lms_coef_clear,
    output logic [15:0]          lms_mu,
    input  logic                 lms_busy,
    output logic                 coef_rd_req,
    output logic [TAP_IDX_W-1:0] coef_rd_idx,
    input  logic                 coef_rd_valid,
    input  logic [31:0]          coef_rd_data
);

    localparam logic [31:0]          COMPAT  = 32'h0001_0000;
    localparam logic [31:0]          NTAPS32 = 32'(NUM_TAPS);
    localparam logic [15:0]          TO_LOAD = 16'(TIMEOUT - 1);
    localparam logic [TAP_IDX_W-1:0] IX_LAST = TAP_IDX_W'(NUM_TAPS - 1);

    typedef enum logic {IDLE, FETCH} state_e;

    state_e               state_q;
    logic                 en_q;
    logic                 adapt_q;
    logic                 clr_q;
    logic [15:0]          mu_q;
    logic [TAP_IDX_W-1:0] ix_q;
    logic                 to_q;
    logic                 ack_q;
    logic [31:0]          rdata_q;
    logic                 req_q;
    logic [15:0]          cnt_q;

    logic [19:0] offset;
    logic        hit;
    logic [2:0]  sel;
    logic        ix_ok;
    logic [31:0] rd_val;
    logic        unused_bits;

    // Offsets below the base wrap to large values and miss the window.
    assign offset = s_ctrlport.req_addr - BASE_ADDR;
    assign hit    = offset < 20'h20;
    assign sel    = offset[4:2];
    assign ix_ok  = 32'(ix_q) < NTAPS32;

    assign unused_bits = ^{s_ctrlport.req_data[31:16], offset[1:0]};

    always_comb begin
        rd_val = '0;
        if (hit) begin
            unique case (sel)
                3'd0:    rd_val = COMPAT;
                3'd1:    rd_val = {30'd0, adapt_q, en_q};
                3'd2:    rd_val = {16'd0, mu_q};
                3'd3:    rd_val = NTAPS32;
                3'd4:    rd_val = 32'(ix_q);
                3'd6:    rd_val = {30'd0, to_q, lms_busy};
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            adapt_q <= 1'b0;
            clr_q   <= 1'b0;
            mu_q    <= MU_DEFAULT;
            ix_q    <= '0;
            to_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            clr_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s_ctrlport.req_wr) begin
                        ack_q <= 1'b1;
                        if (hit) begin
                            case (sel)
                                3'd1: begin
                                    en_q    <= s_ctrlport.req_data[0];
                                    adapt_q <= s_ctrlport.req_data[1];
                                    clr_q   <= s_ctrlport.req_data[2] & ~clr_q;
                                end
                                3'd2: mu_q <= s_ctrlport.req_data[15:0];
                                3'd4: ix_q <= s_ctrlport.req_data[TAP_IDX_W-1:0];
                                3'd6: if (s_ctrlport.req_data[1]) to_q <= 1'b0;
                                default: ;
                            endcase
                        end
                    end else if (s_ctrlport.req_rd) begin
                        if (hit && sel == 3'd5 && ix_ok) begin
                            req_q   <= 1'b1;
                            cnt_q   <= TO_LOAD;
                            state_q <= FETCH;
                        end else begin
                            ack_q   <= 1'b1;
                            rdata_q <= rd_val;
                        end
                    end
                end
                FETCH: begin
                    // Valid in the expiry cycle is checked first and wins.
                    if (coef_rd_valid) begin
                        ack_q   <= 1'b1;
                        rdata_q <= coef_rd_data;
                        req_q   <= 1'b0;
                        ix_q    <= (ix_q == IX_LAST) ? '0 : ix_q + 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        ack_q   <= 1'b1;
                        to_q    <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ctrlport.resp_ack  = ack_q;
    assign s_ctrlport.resp_data = rdata_q;
    assign lms_enable           = en_q;
    assign lms_adapt_en         = adapt_q;
    assign lms_coef_clear       = clr_q;
    assign lms_mu               = mu_q;
    assign coef_rd_req          = req_q;
    assign coef_rd_idx          = ix_q;

endmodule

// File: tb/tb_lms_ctrlport_regs.sv
// Bench for lms_ctrlport_regs: register table, coefficient fetch,
// timeout, windowing with a non-zero base and reset during fetch.
module tb_lms_ctrlport_regs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    lms_ctrlport_if ifa ();
    lms_ctrlport_if ifb ();

    logic        en_a, adapt_a, clr_a, busy_a, req_a, valid_a;
    logic [15:0] mu_a;
    logic [4:0]  idx_a;
    logic [31:0] data_a;
    logic        en_b, adapt_b, clr_b, req_b;
    logic [15:0] mu_b;
    logic [4:0]  idx_b;

    lms_ctrlport_regs u_dut_a (
        .ctrlport_clk   (clk),
        .ctrlport_rst_n (rst_n),
        .s_ctrlport     (ifa),
        .lms_enable     (en_a),
        .lms_adapt_en   (adapt_a),
        .lms_coef_clear (clr_a),
        .lms_mu         (mu_a),
        .lms_busy       (busy_a),
        .coef_rd_req    (req_a),
        .coef_rd_idx    (idx_a),
        .coef_rd_valid  (valid_a),
        .coef_rd_data   (data_a)
    );

    lms_ctrlport_regs #(.BASE_ADDR(20'h00100)) u_dut_b (
        .ctrlport_clk   (clk),
        .ctrlport_rst_n (rst_n),
        .s_ctrlport     (ifb),
        .lms_enable     (en_b),
        .lms_adapt_en   (adapt_b),
        .lms_coef_clear (clr_b),
        .lms_mu         (mu_b),
        .lms_busy       (1'b0),
        .coef_rd_req    (req_b),
        .coef_rd_idx    (idx_b),
        .coef_rd_valid  (1'b0),
        .coef_rd_data   (32'd0)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          s;
        bit          wr;
        bit          rd;
        logic [19:0] addr;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Scoreboard pop side: every ack must match the oldest expectation.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ifa.resp_ack === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL ack_a_unexpected got=%h cyc=%0d", ifa.resp_data, cyc);
            end else begin
                e = q0.pop_front();
                if (ifa.resp_data !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL ack_a got=%h@%0d want=%h@%0d",
                             ifa.resp_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ifb.resp_ack === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL ack_b_unexpected got=%h cyc=%0d", ifb.resp_data, cyc);
            end else begin
                e = q1.pop_front();
                if (ifb.resp_data !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL ack_b got=%h@%0d want=%h@%0d",
                             ifb.resp_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    int clr_cnt = 0;
    int clr_run = 0;
    logic clr_prev = 1'b0;
    always @(negedge clk) begin
        if (clr_a === 1'b1) clr_cnt++;
        if (clr_a === 1'b1 && clr_prev === 1'b1) clr_run++;
        clr_prev = clr_a;
    end

    // Core model: answers a coefficient request after model_delay cycles.
    bit          model_en = 1'b0;
    int          model_delay = 0;
    logic [31:0] model_data = '0;
    logic [4:0]  model_idx = '0;
    always begin
        @(negedge clk);
        if (model_en && req_a === 1'b1 && rst_n) begin
            chk("coef_idx", 32'(idx_a), 32'(model_idx));
            repeat (model_delay) @(posedge clk);
            #1;
            valid_a = 1'b1;
            data_a  = model_data;
            @(posedge clk);
            #1;
            valid_a = 1'b0;
            data_a  = '0;
        end
    end

    task automatic acc(input int s, input bit wr, input bit rd,
                       input logic [19:0] addr, input logic [31:0] d,
                       input logic [31:0] e, input int lat, input bit ack);
        @(posedge clk);
        #1;
        if (s == 0) begin
            ifa.req_wr = wr; ifa.req_rd = rd;
            ifa.req_addr = addr; ifa.req_data = d;
            if (ack) q0.push_back('{data: e, cyc: cyc + lat});
        end else begin
            ifb.req_wr = wr; ifb.req_rd = rd;
            ifb.req_addr = addr; ifb.req_data = d;
            if (ack) q1.push_back('{data: e, cyc: cyc + lat});
        end
        @(posedge clk);
        #1;
        ifa.req_wr = 1'b0; ifa.req_rd = 1'b0;
        ifb.req_wr = 1'b0; ifb.req_rd = 1'b0;
    endtask

    task automatic wait_done(input int s, input int budget);
        int n;
        n = 0;
        while ((s == 0 ? q0.size() : q1.size()) != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if ((s == 0 ? q0.size() : q1.size()) != 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout dut=%0d pending=%0d", s,
                     s == 0 ? q0.size() : q1.size());
            if (s == 0) q0.delete(); else q1.delete();
        end
    endtask

    task automatic coef_fetch_wrap(input string tag);
        acc(0, 1, 0, 20'h10, 32'd31, 32'd0, 1, 1);
        model_en = 1'b1; model_delay = 5;
        model_data = 32'h1234_5678; model_idx = 5'd31;
        acc(0, 0, 1, 20'h14, 32'd0, 32'h1234_5678, 7, 1);
        acc(0, 0, 1, 20'h08, 32'd0, 32'd0, 1, 0);
        chk({tag, "_req_hi"}, 32'(req_a), 32'd1);
        wait_done(0, 50);
        model_en = 1'b0;
        chk({tag, "_req_lo"}, 32'(req_a), 32'd0);
        acc(0, 0, 1, 20'h10, 32'd0, 32'd0, 1, 1);
        wait_done(0, 10);
    endtask

    initial begin
        ifa.req_wr = 1'b0; ifa.req_rd = 1'b0; ifa.req_addr = '0; ifa.req_data = '0;
        ifb.req_wr = 1'b0; ifb.req_rd = 1'b0; ifb.req_addr = '0; ifb.req_data = '0;
        busy_a = 1'b0; valid_a = 1'b0; data_a = '0;

        vt.push_back('{0, 0, 1, 20'h08, 32'h0, 32'h0000_0100});
        vt.push_back('{0, 0, 1, 20'h0C, 32'h0, 32'd32});
        vt.push_back('{0, 0, 1, 20'h00, 32'h0, 32'h0001_0000});
        vt.push_back('{0, 1, 0, 20'h04, 32'h7, 32'h0});
        vt.push_back('{0, 0, 1, 20'h04, 32'h0, 32'h3});
        vt.push_back('{0, 1, 0, 20'h08, 32'hABCD_1234, 32'h0});
        vt.push_back('{0, 0, 1, 20'h08, 32'h0, 32'h0000_1234});
        vt.push_back('{0, 1, 0, 20'h00, 32'hFFFF, 32'h0});
        vt.push_back('{0, 0, 1, 20'h00, 32'h0, 32'h0001_0000});
        vt.push_back('{0, 0, 1, 20'h1C, 32'h0, 32'h0});
        vt.push_back('{0, 0, 1, 20'h20, 32'h0, 32'h0});
        vt.push_back('{0, 1, 1, 20'h08, 32'h0100, 32'h0});
        vt.push_back('{0, 0, 1, 20'h08, 32'h0, 32'h0000_0100});
        vt.push_back('{0, 1, 0, 20'h10, 32'hFFFF_FFE3, 32'h0});
        vt.push_back('{0, 0, 1, 20'h10, 32'h0, 32'h3});
        vt.push_back('{0, 0, 1, 20'h0E, 32'h0, 32'd32});
        vt.push_back('{0, 0, 1, 20'hFFFFC, 32'h0, 32'h0});
        vt.push_back('{1, 0, 1, 20'h040, 32'h0, 32'h0});
        vt.push_back('{1, 0, 1, 20'h140, 32'h0, 32'h0});
        vt.push_back('{1, 1, 0, 20'h108, 32'h55, 32'h0});
        vt.push_back('{1, 0, 1, 20'h108, 32'h0, 32'h55});
        vt.push_back('{1, 0, 1, 20'h100, 32'h0, 32'h0001_0000});
        vt.push_back('{1, 0, 1, 20'h0FC, 32'h0, 32'h0});
        vt.push_back('{1, 0, 1, 20'h11C, 32'h0, 32'h0});

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ifa.resp_ack), 32'd0);
        chk("rst_mu", 32'(mu_a), 32'h100);
        chk("rst_en", {30'd0, adapt_a, en_a}, 32'd0);
        chk("rst_clr", 32'(clr_a), 32'd0);
        chk("rst_req", 32'(req_a), 32'd0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            acc(vt[i].s, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].d, vt[i].e, 1, 1);
            wait_done(vt[i].s, 10);
        end
        chk("t2_enable", 32'(en_a), 32'd1);
        chk("t2_adapt", 32'(adapt_a), 32'd1);
        chk("t2_clr_cnt", 32'(clr_cnt), 32'd1);
        chk("t5_b_mu", 32'(mu_b), 32'h55);

        busy_a = 1'b1;
        acc(0, 0, 1, 20'h18, 32'd0, 32'h1, 1, 1);
        wait_done(0, 10);
        busy_a = 1'b0;

        // Back-to-back clear writes.
        @(posedge clk);
        #1;
        ifa.req_wr = 1'b1; ifa.req_addr = 20'h04; ifa.req_data = 32'h4;
        q0.push_back('{data: 32'h0, cyc: cyc + 1});
        @(posedge clk);
        #1;
        q0.push_back('{data: 32'h0, cyc: cyc + 1});
        @(posedge clk);
        #1;
        ifa.req_wr = 1'b0;
        wait_done(0, 10);
        chk("clr_b2b_seen", 32'(clr_cnt >= 2), 32'd1);
        chk("clr_b2b_run", 32'(clr_run), 32'd0);
        chk("clr_b2b_en", {30'd0, adapt_a, en_a}, 32'd0);

        coef_fetch_wrap("t3");

        model_en = 1'b0;
        acc(0, 0, 1, 20'h14, 32'd0, 32'd0, 256, 1);
        wait_done(0, 400);
        chk("t4_req_lo", 32'(req_a), 32'd0);
        acc(0, 0, 1, 20'h18, 32'd0, 32'h2, 1, 1);
        acc(0, 1, 0, 20'h18, 32'h2, 32'h0, 1, 1);
        acc(0, 0, 1, 20'h18, 32'd0, 32'h0, 1, 1);
        acc(0, 0, 1, 20'h10, 32'd0, 32'h0, 1, 1);
        wait_done(0, 10);

        // Valid lands in the last cycle before expiry.
        model_en = 1'b1; model_delay = 254;
        model_data = 32'hCAFE_0001; model_idx = 5'd0;
        acc(0, 0, 1, 20'h14, 32'd0, 32'hCAFE_0001, 256, 1);
        wait_done(0, 400);
        model_en = 1'b0;
        acc(0, 0, 1, 20'h18, 32'd0, 32'h0, 1, 1);
        acc(0, 0, 1, 20'h10, 32'd0, 32'h1, 1, 1);
        wait_done(0, 10);

        acc(0, 0, 1, 20'h14, 32'd0, 32'd0, 256, 1);
        repeat (10) @(negedge clk);
        chk("t6_req_hi", 32'(req_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(req_a), 32'd0);
        chk("t6_ack", 32'(ifa.resp_ack), 32'd0);
        q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_mu", 32'(mu_a), 32'h100);
        chk("t6_idx", 32'(idx_a), 32'd0);
        repeat (300) @(negedge clk);
        coef_fetch_wrap("t6");

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
